bus_mem_slave: RTL and testbench

BUS_MEM_SLAVE -- requirements
Module: bus_mem_slave

---
 rtl/bus_mem_pkg.sv | 23 ++
 rtl/bus_lane_swap.sv | 18 +
 rtl/bus_mem_slave.sv | 109 ++++++++++
 tb/tb_bus_mem_slave.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_mem_pkg.sv
// rtl/bus_mem_pkg.sv - shared types and constants for the bus memory slave
package bus_mem_pkg;

  localparam int BUS_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_BOTH  = 2'd3;

  function automatic logic [BUS_W-1:0] lane_mask(input logic [BUS_W/8-1:0] be);
    logic [BUS_W-1:0] m;
    for (int i = 0; i < BUS_W/8; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/bus_lane_swap.sv
// rtl/bus_lane_swap.sv - maps bus lanes to memory bytes, reversed or straight
module bus_lane_swap
  import bus_mem_pkg::*;
#(
  parameter int BYTE_SWAP = 1
) (
  input  logic [BUS_W-1:0] din,
  output logic [BUS_W-1:0] dout
);

  // The reversal is its own inverse, so one block serves both directions.
  if (BYTE_SWAP != 0) begin : g_swap
    assign dout = {din[7:0], din[15:8], din[23:16], din[31:24]};
  end else begin : g_straight
    assign dout = din;
  end

endmodule

// File: rtl/bus_mem_slave.sv
// rtl/bus_mem_slave.sv - wait-stated 32-bit memory slave with sticky error code
module bus_mem_slave
  import bus_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter int          BYTE_SWAP   = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic              read,
  input  logic              write,
  input  logic [BUS_W-1:0]  writedata,
  input  logic [3:0]        byteenable,
  output logic              waitrequest,
  output logic [BUS_W-1:0]  readdata,
  output logic [1:0]        err_code
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t            state, state_next;
  logic [3:0]        count, count_next;
  logic [BUS_W-1:0]  mem [DEPTH_WORDS];

  logic              request;
  logic [29:0]       offset_w;
  logic [AW-1:0]     idx;
  logic              in_range;
  logic              misaligned;
  logic [1:0]        access_err;
  logic [BUS_W-1:0]  be_mask;
  logic [BUS_W-1:0]  rd_bus;
  logic [BUS_W-1:0]  wr_mem;
  logic [BUS_W-1:0]  wmask_mem;

  assign request     = read | write;
  assign waitrequest = request && (state != ST_ACK);

  // Modulo-2^32 offset; anything past the array lands in the upper bits.
  assign offset_w   = 30'((address - BASE_ADDR) >> 2);
  assign idx        = offset_w[AW-1:0];
  assign in_range   = (address != '0) && (offset_w[29:AW] == '0);
  assign misaligned = (address[1:0] != 2'b00);
  assign be_mask    = lane_mask(byteenable);

  always_comb begin
    access_err = ERR_NONE;
    if (read && write)  access_err = ERR_BOTH;
    else if (misaligned) access_err = ERR_ALIGN;
    else if (!in_range)  access_err = ERR_RANGE;
  end

  bus_lane_swap #(.BYTE_SWAP(BYTE_SWAP)) u_swap_rd (.din(mem[idx]), .dout(rd_bus));
  bus_lane_swap #(.BYTE_SWAP(BYTE_SWAP)) u_swap_wd (.din(writedata), .dout(wr_mem));
  bus_lane_swap #(.BYTE_SWAP(BYTE_SWAP)) u_swap_be (.din(be_mask),   .dout(wmask_mem));

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      ST_IDLE: begin
        if (request) begin
          count_next = 4'(WAIT_CYCLES);
          state_next = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!request) begin
          state_next = ST_IDLE;
        end else begin
          count_next = count - 4'd1;
          if (count == 4'd1) state_next = ST_ACK;
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      readdata <= '0;
      err_code <= ERR_NONE;
    end else begin
      state <= state_next;
      count <= count_next;
      if (state_next == ST_ACK && state != ST_ACK) begin
        readdata <= (read && access_err == ERR_NONE) ? (rd_bus & be_mask) : '0;
      end
      if (state == ST_ACK && request && err_code == ERR_NONE) begin
        err_code <= access_err;
      end
    end
  end

  // Memory is deliberately outside the reset domain; reset only gates the commit.
  always_ff @(posedge clk) begin
    if (state == ST_ACK && write && !reset && access_err == ERR_NONE) begin
      mem[idx] <= (mem[idx] & ~wmask_mem) | (wr_mem & wmask_mem);
    end
  end

endmodule

// File: tb/tb_bus_mem_slave.sv
// tb/tb_bus_mem_slave.sv - scoreboard bench for bus_mem_slave
module tb_bus_mem_slave;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [1:0]  err_code;

  logic [31:0] z_address;
  logic        z_read;
  logic        z_write;
  logic [31:0] z_writedata;
  logic [3:0]  z_byteenable;
  logic        z_waitrequest;
  logic [31:0] z_readdata;
  logic [1:0]  z_err_code;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  bus_mem_slave dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
    .readdata(readdata), .err_code(err_code)
  );

  bus_mem_slave #(.WAIT_CYCLES(0), .BYTE_SWAP(0)) dut0 (
    .clk(clk), .reset(reset), .address(z_address), .read(z_read), .write(z_write),
    .writedata(z_writedata), .byteenable(z_byteenable), .waitrequest(z_waitrequest),
    .readdata(z_readdata), .err_code(z_err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset;
    read = 1'b0; write = 1'b0; z_read = 1'b0; z_write = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Drives one transfer from posedge+1, pops the scoreboard at the ACK cycle.
  task automatic bus_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be,
                          input logic [31:0] exp_rd, input int exp_wait, input string name);
    int waits;
    bit done;
    logic [31:0] e;
    if (rd) exp_q.push_back(exp_rd);
    address = addr; read = rd; write = wr; writedata = wd; byteenable = be;
    waits = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (waitrequest) waits++;
      else done = 1;
    end
    checks++;
    if (!done || waits != exp_wait) begin
      errors++;
      $display("FAIL %s wait_cycles: got %0d (done=%0d) expected %0d", name, waits, done, exp_wait);
    end
    if (rd) begin
      e = exp_q.pop_front();
      checks++;
      if (readdata !== e) begin
        errors++;
        $display("FAIL %s readdata: got %h expected %h", name, readdata, e);
      end
    end
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (waitrequest !== 1'b0 || readdata !== 32'h0 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%b rd=%h err=%0d expected 0 0 0", waitrequest, readdata, err_code);
    end
    checks++;
    if (z_waitrequest !== 1'b0 || z_readdata !== 32'h0 || z_err_code !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs_w0: got wr=%b rd=%h err=%0d expected 0 0 0", z_waitrequest, z_readdata, z_err_code);
    end
    read = 1'b1;
    #1;
    checks++;
    if (waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL reset_waitrequest: got %b expected 1", waitrequest);
    end
    read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_write_read;
    bus_xfer(0, 1, 32'hBFC00004, 32'h11223344, 4'hF, 32'h0, 3, "wr_full");
    bus_xfer(1, 0, 32'hBFC00004, 32'h0, 4'hF, 32'h11223344, 3, "rd_full");
    checks++;
    if (err_code !== 2'd0) begin
      errors++;
      $display("FAIL wr_rd_err: got %0d expected 0", err_code);
    end
    bus_xfer(0, 1, 32'hBFC00004, 32'hAABBCCDD, 4'b0100, 32'h0, 3, "wr_lane2");
    bus_xfer(1, 0, 32'hBFC00004, 32'h0, 4'hF, 32'h11BB3344, 3, "rd_after_lane2");
    bus_xfer(1, 0, 32'hBFC00004, 32'h0, 4'b0001, 32'h00000044, 3, "rd_lane0_only");
  endtask

  task automatic test_swap;
    bus_xfer(1, 0, 32'hBFC00000, 32'h0, 4'hF, 32'h04030201, 3, "swap1_rd");
  endtask

  task automatic test_back_to_back;
    logic [31:0] e;
    exp_q.push_back(32'h01020304);
    exp_q.push_back(32'hCAFEF00D);
    z_address = 32'hBFC00000; z_byteenable = 4'hF; z_read = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (z_waitrequest !== 1'b1) begin
        errors++;
        $display("FAIL b2b_stall%0d: got %b expected 1", k, z_waitrequest);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (z_waitrequest !== 1'b0 || z_readdata !== e) begin
        errors++;
        $display("FAIL b2b_ack%0d: got wr=%b rd=%h expected 0 %h", k, z_waitrequest, z_readdata, e);
      end
      @(posedge clk); #1;
      z_address = 32'hBFC00004;
    end
    z_read = 1'b0;
  endtask

  task automatic test_errors;
    do_reset();
    bus_xfer(1, 0, 32'h00000000, 32'h0, 4'hF, 32'h0, 3, "err_zero_rd");
    checks++;
    if (err_code !== 2'd1) begin
      errors++;
      $display("FAIL err_zero: got %0d expected 1", err_code);
    end
    bus_xfer(1, 0, 32'hBFC00002, 32'h0, 4'hF, 32'h0, 3, "err_sticky_rd");
    checks++;
    if (err_code !== 2'd1) begin
      errors++;
      $display("FAIL err_sticky: got %0d expected 1", err_code);
    end
    do_reset();
    bus_xfer(1, 0, 32'hBFC00002, 32'h0, 4'hF, 32'h0, 3, "err_misal_rd");
    checks++;
    if (err_code !== 2'd2) begin
      errors++;
      $display("FAIL err_misal: got %0d expected 2", err_code);
    end
    do_reset();
    bus_xfer(1, 1, 32'hBFC00000, 32'hFFFFFFFF, 4'hF, 32'h0, 3, "err_both");
    checks++;
    if (err_code !== 2'd3) begin
      errors++;
      $display("FAIL err_both: got %0d expected 3", err_code);
    end
    do_reset();
    bus_xfer(0, 1, 32'hBFC01000, 32'hFFFFFFFF, 4'hF, 32'h0, 3, "err_oor_wr");
    checks++;
    if (err_code !== 2'd1) begin
      errors++;
      $display("FAIL err_oor: got %0d expected 1", err_code);
    end
    bus_xfer(0, 1, 32'hBFC00001, 32'hFFFFFFFF, 4'hF, 32'h0, 3, "err_misal_wr");
    bus_xfer(1, 0, 32'hBFC00000, 32'h0, 4'hF, 32'h04030201, 3, "err_no_write");
    bus_xfer(0, 1, 32'hBFC00FFC, 32'hA5A55A5A, 4'hF, 32'h0, 3, "last_word_wr");
    bus_xfer(1, 0, 32'hBFC00FFC, 32'h0, 4'hF, 32'hA5A55A5A, 3, "last_word_rd");
  endtask

  task automatic test_abort_reset;
    bus_xfer(0, 1, 32'hBFC00008, 32'hDEADBEEF, 4'hF, 32'h0, 3, "abort_pre_wr");
    bus_xfer(1, 0, 32'hBFC00008, 32'h0, 4'hF, 32'hDEADBEEF, 3, "abort_pre_rd");
    address = 32'hBFC00008; writedata = 32'h12345678; byteenable = 4'hF; write = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (waitrequest !== 1'b1 || readdata !== 32'h0 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL abort_outputs: got wr=%b rd=%h err=%0d expected 1 0 0", waitrequest, readdata, err_code);
    end
    @(posedge clk); #1;
    write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    bus_xfer(1, 0, 32'hBFC00008, 32'h0, 4'hF, 32'hDEADBEEF, 3, "abort_no_write");
  endtask

  task automatic test_drop;
    do_reset();
    address = 32'hBFC00008; writedata = 32'h0BADF00D; byteenable = 4'hF; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (err_code !== 2'd0) begin
      errors++;
      $display("FAIL drop_err: got %0d expected 0", err_code);
    end
    bus_xfer(1, 0, 32'hBFC00008, 32'h0, 4'hF, 32'hDEADBEEF, 3, "drop_no_write");
  endtask

  initial begin
    reset = 1'b1;
    address = '0; read = 1'b0; write = 1'b0; writedata = '0; byteenable = '0;
    z_address = '0; z_read = 1'b0; z_write = 1'b0; z_writedata = '0; z_byteenable = '0;
    dut.mem[0]  <= 32'h01020304;
    dut0.mem[0] <= 32'h01020304;
    dut0.mem[1] <= 32'hCAFEF00D;
    test_reset();
    test_write_read();
    test_swap();
    test_back_to_back();
    test_errors();
    test_abort_reset();
    test_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
